// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard and forwarding controller for the 5-stage WISC pipeline.
// Tracks the execute/memory producers in a 2-slot scoreboard and drives forward/stall controls.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic             id_regWrite,
    input  logic [2:0]       id_writeReg,
    input  logic             id_memRead,
    input  logic [1:0]       id_regSrc,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic             forward_XX_A,
    output logic             forward_XX_B,
    output logic             forward_XM_A,
    output logic             forward_XM_B,
    output logic [1:0]       forward_XX_sel,
    output logic [1:0]       forward_XM_sel,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [2:0] rd;
        logic       ld;
        logic [1:0] src;
    } sb_entry_t;

    sb_entry_t        r_dx;
    sb_entry_t        r_xm;
    sb_entry_t        w_id_entry;
    logic [CNT_W-1:0] r_stall_count;

    logic w_m_dx_a, w_m_dx_b, w_m_xm_a, w_m_xm_b;
    logic w_stall, w_fwd_en;
    logic w_xx_a, w_xx_b, w_xm_a, w_xm_b;

    assign w_id_entry = '{v: 1'b1, wr: id_regWrite, rd: id_writeReg, ld: id_memRead, src: id_regSrc};

    assign w_m_dx_a = r_dx.v & r_dx.wr & id_rs_used & (r_dx.rd == id_rs);
    assign w_m_dx_b = r_dx.v & r_dx.wr & id_rt_used & (r_dx.rd == id_rt);
    assign w_m_xm_a = r_xm.v & r_xm.wr & id_rs_used & (r_xm.rd == id_rs);
    assign w_m_xm_b = r_xm.v & r_xm.wr & id_rt_used & (r_xm.rd == id_rt);

    // A load one ahead has no data yet; flush squashes decode, so it beats the stall.
    assign w_stall  = id_valid & ~flush & r_dx.ld & (w_m_dx_a | w_m_dx_b);
    assign w_fwd_en = id_valid & ~w_stall & ~flush;

    assign w_xx_a = w_fwd_en & w_m_dx_a & ~r_dx.ld;
    assign w_xx_b = w_fwd_en & w_m_dx_b & ~r_dx.ld;
    assign w_xm_a = w_fwd_en & w_m_xm_a & ~w_xx_a;
    assign w_xm_b = w_fwd_en & w_m_xm_b & ~w_xx_b;

    assign stall          = w_stall;
    assign forward_XX_A   = w_xx_a;
    assign forward_XX_B   = w_xx_b;
    assign forward_XM_A   = w_xm_a;
    assign forward_XM_B   = w_xm_b;
    assign forward_XX_sel = (w_xx_a | w_xx_b) ? r_dx.src : 2'b00;
    assign forward_XM_sel = (w_xm_a | w_xm_b) ? r_xm.src : 2'b00;
    assign stall_count    = r_stall_count;

    // NOTE: non-blocking assignments here so r_xm samples the old r_dx, mirroring the pipeline shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dx          <= '0;
            r_xm          <= '0;
            r_stall_count <= '0;
        end else if (!mem_stall) begin
            r_xm <= r_dx;
            r_dx <= w_fwd_en ? w_id_entry : '0;
            if (w_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit (counter narrowed to 4 bits to reach saturation).
module tb_hazard_fwd_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [2:0]       id_rs;
    logic             id_rs_used;
    logic [2:0]       id_rt;
    logic             id_rt_used;
    logic             id_regWrite;
    logic [2:0]       id_writeReg;
    logic             id_memRead;
    logic [1:0]       id_regSrc;
    logic             flush;
    logic             mem_stall;
    logic             stall;
    logic             forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B;
    logic [1:0]       forward_XX_sel, forward_XM_sel;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .id_rt         (id_rt),
        .id_rt_used    (id_rt_used),
        .id_regWrite   (id_regWrite),
        .id_writeReg   (id_writeReg),
        .id_memRead    (id_memRead),
        .id_regSrc     (id_regSrc),
        .flush         (flush),
        .mem_stall     (mem_stall),
        .stall         (stall),
        .forward_XX_A  (forward_XX_A),
        .forward_XX_B  (forward_XX_B),
        .forward_XM_A  (forward_XM_A),
        .forward_XM_B  (forward_XM_B),
        .forward_XX_sel(forward_XX_sel),
        .forward_XM_sel(forward_XM_sel),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one decode instruction: valid, rs, rs_used, rt, rt_used, regWrite, writeReg, memRead, regSrc.
    task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic wr, input logic [2:0] wd, input logic ld,
                         input logic [1:0] src);
        id_valid    = v;
        id_rs       = rs;
        id_rs_used  = rsu;
        id_rt       = rt;
        id_rt_used  = rtu;
        id_regWrite = wr;
        id_writeReg = wd;
        id_memRead  = ld;
        id_regSrc   = src;
    endtask

    task automatic bubble();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector: {stall, XX_A, XX_B, XM_A, XM_B, XX_sel[1:0], XM_sel[1:0]}.
    task automatic expect_out(input string tag, input logic [8:0] exp);
        #2;
        check(tag, {23'd0, stall, forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B,
                    forward_XX_sel, forward_XM_sel}, {23'd0, exp});
    endtask

    task automatic expect_cnt(input string tag, input logic [CNT_W-1:0] exp);
        check(tag, {{(32-CNT_W){1'b0}}, stall_count}, {{(32-CNT_W){1'b0}}, exp});
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        mem_stall = 1'b0;
        bubble();
        tick();
        tick();
        rst = 1'b1;

        // Reset state: reader of r0 in both operands sees nothing.
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        expect_out("reset_outputs", 9'b0_00_00_00_00);
        expect_cnt("reset_count", 4'd0);
        tick();

        // ADD r3 then SUB reading r3 as A.
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 2'b00);
        expect_out("add_r3_issue", 9'b0_00_00_00_00);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 1'b1, 3'd6, 1'b0, 2'b00);
        expect_out("xx_fwd_A", 9'b0_10_00_00_00);
        tick();
        bubble();
        expect_out("bubble_no_match", 9'b0_00_00_00_00);
        tick();
        tick();

        // LD r2 then ADD reading r2 as B: one stall, then XM forward.
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 2'b11);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd7, 1'b0, 2'b01);
        expect_out("load_use_stall", 9'b1_00_00_00_00);
        tick();
        expect_cnt("count_after_stall", 4'd1);
        expect_out("load_xm_fwd_B", 9'b0_00_01_00_11);
        tick();
        bubble();
        tick();
        tick();

        // r5 written 2 ahead (src 10) and 1 ahead (src 01): nearer wins.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b10);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b01);
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        expect_out("nearer_wins_AB", 9'b0_11_00_01_00);
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        expect_out("xm_fwd_A_src01", 9'b0_00_10_00_01);
        tick();
        bubble();
        tick();
        tick();

        // Load then dependent with flush: no stall, no forward, flushed writer not recorded.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 2'b11);
        tick();
        drive(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 2'b10);
        flush = 1'b1;
        expect_out("flush_beats_stall", 9'b0_00_00_00_00);
        expect_cnt("flush_count_hold", 4'd1);
        tick();
        flush = 1'b0;
        drive(1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        expect_out("after_flush_dx_empty", 9'b0_00_10_00_11);
        tick();
        bubble();
        tick();
        tick();

        // mem_stall for 3 cycles behind a pending load: stall persists, count frozen.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 2'b11);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 2'b00);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("memstall_hold_%0d", i), 9'b1_00_00_00_00);
            expect_cnt($sformatf("memstall_cnt_%0d", i), 4'd1);
            tick();
        end
        mem_stall = 1'b0;
        expect_out("memstall_release", 9'b1_00_00_00_00);
        tick();
        expect_cnt("memstall_cnt_after", 4'd2);
        expect_out("memstall_xm_fwd", 9'b0_00_10_00_11);
        tick();

        // ADD producer frozen by mem_stall keeps forwarding XX.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 2'b10);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("memstall_fwd_%0d", i), 9'b0_01_00_10_00);
            tick();
        end
        mem_stall = 1'b0;
        bubble();
        tick();
        tick();

        // Reset mid-sequence with both slots valid, mem_stall asserted.
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 2'b01);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 2'b10);
        tick();
        rst = 1'b0;
        mem_stall = 1'b1;
        drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
        tick();
        rst = 1'b1;
        mem_stall = 1'b0;
        expect_out("midreset_outputs", 9'b0_00_00_00_00);
        expect_cnt("midreset_count", 4'd0);
        bubble();
        tick();

        // Saturation of the counter: 17 load-use pairs into a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 2'b11);
            tick();
            drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00);
            tick();
            if (i == 13) expect_cnt("count_14", 4'd14);
        end
        expect_cnt("count_saturated", 4'hF);
        bubble();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
